// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS program loader: FSM encoding,
// header length width and checksum width.
package mips_loader_pkg;
  localparam int LEN_W = 16;
  localparam int CHK_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_t;
endpackage

// File: rtl/mips_prog_loader_if.sv
// Byte-stream input and memory write port of the program loader.
// Stream handshake: a byte moves on a clk1 rising edge where s_valid && s_ready;
// the source holds s_data stable while s_valid is high and s_ready is low.
interface mips_prog_loader_if #(parameter int ADDR_W = 10);
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (output s_data, s_valid, input s_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (input s_data, s_valid, output s_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/mips_word_assembler.sv
// Collects four stream bytes MSB first into a 32-bit word; word_valid marks
// the byte that completes a word, with word already holding the full value.
module mips_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [23:0] shift_q;
  logic [1:0]  idx_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (byte_en) begin
      shift_q <= {shift_q[15:0], byte_in};
      idx_q   <= idx_q + 2'd1;
    end
  end

  assign word       = {shift_q, byte_in};
  assign word_valid = byte_en && (idx_q == 2'd3);
endmodule

// File: rtl/mips_prog_loader.sv
// Loads CPU memory from a framed byte stream (length header, payload, checksum)
// and releases the CPU from hold once the frame checks out.
module mips_prog_loader #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 16
) (
  input  logic                           clk1,
  input  logic                           rst_n,
  input  logic                           start,
  mips_prog_loader_if.slave              bus,
  output logic                           cpu_hold,
  output logic                           cpu_go,
  output logic                           load_done,
  output logic                           load_err,
  output logic [ADDR_W:0]                words_loaded,
  output mips_loader_pkg::loader_state_t dbg_state
);
  import mips_loader_pkg::*;

  localparam int unsigned CAP = 32'd1 << ADDR_W;

  loader_state_t     state_q, state_n;
  logic              ready, accept, start_ok;
  logic              byte_en, word_valid, last_word, csum_ok, len_zero, len_over;
  logic [31:0]       word;
  logic [7:0]        len_hi_q;
  logic [LEN_W-1:0]  len_q, len_full;
  logic [CHK_W-1:0]  csum_q;
  logic [ADDR_W:0]   words_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  assign ready     = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                     (state_q == ST_DATA)   || (state_q == ST_CHK);
  assign accept    = ready && bus.s_valid;
  assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
  assign byte_en   = accept && (state_q == ST_DATA);
  assign len_full  = LEN_W'({len_hi_q, bus.s_data});
  assign len_zero  = (len_full == '0);
  assign len_over  = 32'(len_full) > CAP;
  assign last_word = (LEN_W'(words_q) + LEN_W'(1)) == len_q;
  assign csum_ok   = (bus.s_data == csum_q);

  mips_word_assembler u_asm (
    .clk        (clk1),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .byte_en    (byte_en),
    .byte_in    (bus.s_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk1) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_n = ST_LEN_HI;
      ST_LEN_HI: if (accept) state_n = ST_LEN_LO;
      ST_LEN_LO: begin
        if (accept) begin
          if (len_zero)      state_n = ST_CHK;
          else if (len_over) state_n = ST_ERR;
          else               state_n = ST_DATA;
        end
      end
      ST_DATA: if (word_valid && last_word) state_n = ST_CHK;
      ST_CHK:  if (accept) state_n = csum_ok ? ST_DONE : ST_ERR;
      default: state_n = ST_IDLE;
    endcase
  end

  // Write strobe and CPU release are registered so they appear the cycle after the deciding byte.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      len_hi_q  <= '0;
      len_q     <= '0;
      csum_q    <= '0;
      words_q   <= '0;
      mem_we_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_hold  <= 1'b1;
      cpu_go    <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      cpu_go   <= 1'b0;
      if (start_ok) begin
        load_done <= 1'b0;
        load_err  <= 1'b0;
        words_q   <= '0;
        csum_q    <= '0;
        cpu_hold  <= 1'b1;
      end
      if (accept && state_q == ST_LEN_HI) len_hi_q <= bus.s_data;
      if (accept && state_q == ST_LEN_LO) begin
        len_q <= len_full;
        if (!len_zero && len_over) load_err <= 1'b1;
      end
      if (byte_en) begin
        csum_q <= csum_q + CHK_W'(bus.s_data);
        if (word_valid) begin
          mem_we_q <= 1'b1;
          addr_q   <= words_q[ADDR_W-1:0];
          wdata_q  <= word;
          words_q  <= words_q + 1'b1;
        end
      end
      if (accept && state_q == ST_CHK) begin
        if (csum_ok) begin
          load_done <= 1'b1;
          cpu_go    <= 1'b1;
          cpu_hold  <= 1'b0;
        end else begin
          load_err  <= 1'b1;
        end
      end
    end
  end

  assign bus.s_ready   = ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign words_loaded  = words_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_mips_prog_loader.sv
// Scenario bench for the program loader: frames are driven byte by byte and
// every memory write is matched against an expected {addr,data} queue.
module tb_mips_prog_loader;
  import mips_loader_pkg::*;

  localparam int ADDR_W = 10;
  localparam int EW     = ADDR_W + 32;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              cpu_hold, cpu_go, load_done, load_err;
  logic [ADDR_W:0]   words_loaded;
  loader_state_t     dbg_state;

  mips_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  mips_prog_loader #(.ADDR_W(ADDR_W), .LEN_W(16)) dut (
    .clk1         (clk1),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .cpu_go       (cpu_go),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded),
    .dbg_state    (dbg_state)
  );

  always #5 clk1 = ~clk1;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  int go_cnt = 0;
  logic [EW-1:0] exp_q[$];
  logic [31:0]   fw[$];

  // Scoreboard: every observed write must match the oldest expected one.
  always @(negedge clk1) begin
    if (cpu_go) go_cnt++;
    if (bus.mem_we) begin
      logic [EW-1:0] e;
      wr_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write addr=%h data=%h", bus.mem_addr, bus.mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== e) begin
          miscompares++;
          $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                   bus.mem_addr, bus.mem_wdata, e[EW-1:32], e[31:0]);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk1); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk1); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit rdy;
    int n;
    repeat ($urandom_range(0, gap)) begin
      bus.s_data = 8'($urandom);
      @(posedge clk1); #1;
    end
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk1);
      rdy = bus.s_ready;
      @(posedge clk1); #1;
      n++;
    end while (!rdy && n < 200);
    bus.s_valid = 1'b0;
    if (!rdy) begin
      miscompares++;
      $display("FAIL send_byte_timeout got s_ready=0 want 1");
      $fatal(1, "stream stalled");
    end
  endtask

  task automatic send_header(input logic [15:0] len, input int gap);
    send_byte(len[15:8], gap);
    send_byte(len[7:0], gap);
  endtask

  task automatic send_payload(input int gap);
    for (int i = 0; i < fw.size(); i++) begin
      for (int j = 3; j >= 0; j--) begin
        if (j == 0) exp_q.push_back({ADDR_W'(i), fw[i]});
        send_byte(fw[i][8*j +: 8], gap);
      end
    end
  endtask

  task automatic set_program();
    fw = {32'h28010001, 32'h28020002, 32'h00221800, 32'h00232000};
  endtask

  task automatic check_done(input string name, input int nwords, input int go0, input int wr0);
    wait_cycles(3);
    vectors += 6;
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL %s_pending got %0d want 0", name, exp_q.size()); end
    if (wr_cnt - wr0 !== nwords) begin miscompares++; $display("FAIL %s_writes got %0d want %0d", name, wr_cnt - wr0, nwords); end
    if (go_cnt - go0 !== 1) begin miscompares++; $display("FAIL %s_cpu_go got %0d want 1", name, go_cnt - go0); end
    if ({load_done, load_err, cpu_hold} !== 3'b100) begin
      miscompares++; $display("FAIL %s_flags got done/err/hold=%b want 100", name, {load_done, load_err, cpu_hold});
    end
    if (words_loaded !== (ADDR_W+1)'(nwords)) begin miscompares++; $display("FAIL %s_words got %0d want %0d", name, words_loaded, nwords); end
    if (dbg_state !== ST_DONE) begin miscompares++; $display("FAIL %s_state got %0d want %0d", name, dbg_state, ST_DONE); end
  endtask

  task automatic test_reset();
    bus.s_data = '0; bus.s_valid = 1'b0;
    rst_n = 1'b0;
    wait_cycles(3);
    vectors++;
    if ({cpu_hold, cpu_go, load_done, load_err, bus.mem_we, bus.s_ready} !== 6'b100000 ||
        words_loaded !== '0 || dbg_state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL reset got hold/go/done/err/we/rdy=%b words=%0d state=%0d want 100000 0 0",
               {cpu_hold, cpu_go, load_done, load_err, bus.mem_we, bus.s_ready}, words_loaded, dbg_state);
    end
    rst_n = 1'b1;
    wait_cycles(1);
  endtask

  task automatic test_program_load();
    int go0 = go_cnt, wr0 = wr_cnt;
    set_program();
    vectors++;
    if (bus.s_ready !== 1'b0) begin miscompares++; $display("FAIL ready_at_start got %b want 0", bus.s_ready); end
    pulse_start();
    send_header(16'd4, 0);
    send_payload(0);
    send_byte(8'hD3, 0);
    check_done("program", 4, go0, wr0);
  endtask

  task automatic test_bad_checksum();
    int go0 = go_cnt, wr0 = wr_cnt;
    set_program();
    pulse_start();
    send_header(16'd4, 0);
    send_payload(0);
    send_byte(8'hD4, 0);
    wait_cycles(3);
    vectors += 4;
    if (wr_cnt - wr0 !== 4) begin miscompares++; $display("FAIL badchk_writes got %0d want 4", wr_cnt - wr0); end
    if (go_cnt !== go0) begin miscompares++; $display("FAIL badchk_cpu_go got %0d want 0", go_cnt - go0); end
    if ({load_done, load_err, cpu_hold} !== 3'b011) begin
      miscompares++; $display("FAIL badchk_flags got done/err/hold=%b want 011", {load_done, load_err, cpu_hold});
    end
    if (dbg_state !== ST_ERR) begin miscompares++; $display("FAIL badchk_state got %0d want %0d", dbg_state, ST_ERR); end
  endtask

  task automatic test_overflow();
    int go0 = go_cnt, wr0 = wr_cnt;
    pulse_start();
    send_header(16'h0401, 0);
    vectors++;
    if (dbg_state !== ST_ERR || load_err !== 1'b1) begin
      miscompares++; $display("FAIL overflow_state got state=%0d err=%b want %0d 1", dbg_state, load_err, ST_ERR);
    end
    wait_cycles(4);
    vectors += 2;
    if (bus.s_ready !== 1'b0) begin miscompares++; $display("FAIL overflow_ready got %b want 0", bus.s_ready); end
    if (wr_cnt !== wr0 || go_cnt !== go0) begin
      miscompares++; $display("FAIL overflow_activity got writes=%0d go=%0d want 0 0", wr_cnt - wr0, go_cnt - go0);
    end
  endtask

  task automatic test_zero_length();
    int go0 = go_cnt, wr0 = wr_cnt;
    fw = {};
    pulse_start();
    send_header(16'h0000, 0);
    vectors++;
    if (dbg_state !== ST_CHK) begin miscompares++; $display("FAIL zero_to_chk got %0d want %0d", dbg_state, ST_CHK); end
    send_byte(8'h00, 0);
    check_done("zero", 0, go0, wr0);
  endtask

  task automatic test_stalls();
    int go0 = go_cnt, wr0 = wr_cnt;
    set_program();
    pulse_start();
    send_header(16'd4, 3);
    pulse_start();
    vectors++;
    if (dbg_state !== ST_DATA) begin miscompares++; $display("FAIL start_ignored got %0d want %0d", dbg_state, ST_DATA); end
    send_payload(4);
    send_byte(8'hD3, 3);
    check_done("stalls", 4, go0, wr0);
  endtask

  task automatic test_reset_midload();
    int go0, wr0;
    set_program();
    pulse_start();
    send_header(16'd4, 0);
    for (int j = 3; j >= 0; j--) begin
      if (j == 0) exp_q.push_back({ADDR_W'(0), fw[0]});
      send_byte(fw[0][8*j +: 8], 0);
    end
    send_byte(fw[1][31:24], 0);
    send_byte(fw[1][23:16], 0);
    wr0 = wr_cnt;
    rst_n = 1'b0;
    wait_cycles(2);
    vectors++;
    if (dbg_state !== ST_IDLE || cpu_hold !== 1'b1 || bus.s_ready !== 1'b0) begin
      miscompares++; $display("FAIL midreset got state=%0d hold=%b rdy=%b want 0 1 0", dbg_state, cpu_hold, bus.s_ready);
    end
    rst_n = 1'b1;
    wait_cycles(10);
    vectors++;
    if (wr_cnt !== wr0 || exp_q.size() !== 0) begin
      miscompares++; $display("FAIL midreset_writes got extra=%0d pending=%0d want 0 0", wr_cnt - wr0, exp_q.size());
    end
    go0 = go_cnt; wr0 = wr_cnt;
    pulse_start();
    send_header(16'd4, 1);
    send_payload(1);
    send_byte(8'hD3, 1);
    check_done("reload", 4, go0, wr0);
  endtask

  task automatic test_restart_after_done();
    int go0 = go_cnt, wr0 = wr_cnt;
    fw = {32'hFFFFFFFF};
    pulse_start();
    vectors++;
    if (load_done !== 1'b0 || cpu_hold !== 1'b1 || words_loaded !== '0 || dbg_state !== ST_LEN_HI) begin
      miscompares++; $display("FAIL restart_clear got done=%b hold=%b words=%0d state=%0d want 0 1 0 %0d",
                              load_done, cpu_hold, words_loaded, dbg_state, ST_LEN_HI);
    end
    send_header(16'd1, 0);
    send_payload(0);
    send_byte(8'hFC, 0);
    check_done("restart", 1, go0, wr0);
  endtask

  initial begin
    test_reset();
    test_program_load();
    test_bad_checksum();
    test_overflow();
    test_zero_length();
    test_stalls();
    test_reset_midload();
    test_restart_after_done();
    wait_cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
